// File: rtl/mat_source_if.sv
`default_nettype none
// ============================================================================
// Module   : mat_source_if
// Purpose  : Bundles the load-side and read-side signals of mat_source.
//            master = the block feeding/reading the matrix, slave = mat_source.
// Signals  : load, din, din_vld         -> matrix load stream
//            busy, full                 <- load/serve status
//            rd, addr                   -> read request
//            data, data_vld, rd_err     <- registered read response
// Revision : 1.0 - initial release
// ============================================================================
interface mat_source_if #(
   parameter int DW = 16,
   parameter int AW = 8
);
   logic          load;
   logic [DW-1:0] din;
   logic          din_vld;
   logic          busy;
   logic          full;
   logic          rd;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          data_vld;
   logic          rd_err;

   modport master (
      output load, din, din_vld, rd, addr,
      input  busy, full, data, data_vld, rd_err
   );

   modport slave (
      input  load, din, din_vld, rd, addr,
      output busy, full, data, data_vld, rd_err
   );
endinterface
`default_nettype wire

// File: rtl/mat_source.sv
`default_nettype none
// ============================================================================
// Module   : mat_source
// Purpose  : Stores an 8x8 matrix (DEPTH words, raster order) streamed in
//            after a load pulse, then serves random-access reads with a
//            one-cycle registered latency.
// Ports    : clk   - single clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - mat_source_if.slave (load stream, status, read port)
// Revision : 1.0 - initial release
// ============================================================================
module mat_source #(
   parameter int DW    = 16,
   parameter int AW    = 8,
   parameter int DEPTH = 64
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   mat_source_if.slave   bus
);

   localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_pw-1:0] c_last = c_pw'(DEPTH - 1);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_load  = 2'd1;
   localparam logic [1:0] c_st_serve = 2'd2;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [c_pw-1:0] r_wptr;
   logic [c_pw-1:0] w_wptr_nxt;
   logic            w_we;
   logic            w_busy;
   logic            w_full;
   logic            w_addr_ok;

   logic [DW-1:0]   r_mem [DEPTH];
   logic [DW-1:0]   r_data;
   logic            r_data_vld;
   logic            r_rd_err;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_wptr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wptr  <= w_wptr_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   // A load pulse always restarts from index 0 and wins over a same-cycle
   // din_vld, so that word is never written.
   always_comb begin
      w_state_nxt = r_state;
      w_wptr_nxt  = r_wptr;
      w_we        = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (bus.load) begin
               w_state_nxt = c_st_load;
               w_wptr_nxt  = '0;
            end
         end
         c_st_load: begin
            if (bus.load) begin
               w_wptr_nxt = '0;
            end else if (bus.din_vld) begin
               w_we       = 1'b1;
               w_wptr_nxt = r_wptr + 1'b1;
               if (r_wptr == c_last) begin
                  w_state_nxt = c_st_serve;
               end
            end
         end
         c_st_serve: begin
            if (bus.load) begin
               w_state_nxt = c_st_load;
               w_wptr_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = c_st_idle;
            w_wptr_nxt  = '0;
         end
      endcase
   end

   // -------------------------------------------------------------- outputs
   // Status decodes straight from the state, so busy and full are exclusive.
   always_comb begin
      w_busy = (r_state == c_st_load);
      w_full = (r_state == c_st_serve);
   end

   assign bus.busy     = w_busy;
   assign bus.full     = w_full;
   assign bus.data     = r_data;
   assign bus.data_vld = r_data_vld;
   assign bus.rd_err   = r_rd_err;

   // --------------------------------------------------------------- memory
   // Deliberately not reset: contents survive reset and partial reloads.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[r_wptr] <= bus.din;
      end
   end

   // ------------------------------------------------------------ read port
   // Zero-extend before comparing so addresses wider than the index range
   // are rejected rather than aliased.
   assign w_addr_ok = ({{(32-AW){1'b0}}, bus.addr} < 32'(DEPTH));

   // A read in the same SERVE cycle as a load pulse still sees the old
   // contents because the state here is the pre-load state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data     <= '0;
         r_data_vld <= 1'b0;
         r_rd_err   <= 1'b0;
      end else if (bus.rd) begin
         if (r_state == c_st_serve) begin
            r_data_vld <= 1'b1;
            if (w_addr_ok) begin
               r_data   <= r_mem[bus.addr[c_pw-1:0]];
               r_rd_err <= 1'b0;
            end else begin
               r_data   <= {DW{1'b1}};
               r_rd_err <= 1'b1;
            end
         end else begin
            r_data     <= {DW{1'b1}};
            r_data_vld <= 1'b0;
            r_rd_err   <= 1'b1;
         end
      end else begin
         r_data_vld <= 1'b0;
         r_rd_err   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mat_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_source
// Purpose  : Directed, self-checking bench for mat_source: table-driven read
//            vectors in SERVE plus hand-written load/reset/restart sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_source;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 64;

   typedef struct {
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] exp_data;
      logic          exp_vld;
      logic          exp_err;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_err    = 0;
   vec_t tbl [8];

   always #5 clk = ~clk;

   mat_source_if #(.DW(DW), .AW(AW)) bus_if ();

   mat_source #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rd(input string name, input logic [DW-1:0] d, input logic v, input logic e);
      chk({name, ".data"},     32'(bus_if.data),     32'(d));
      chk({name, ".data_vld"}, 32'(bus_if.data_vld), 32'(v));
      chk({name, ".rd_err"},   32'(bus_if.rd_err),   32'(e));
   endtask

   // busy and full must never be high together
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if (bus_if.busy && bus_if.full) begin
            n_err++;
            $display("FAIL busy_full_excl: busy=%b full=%b at %0t", bus_if.busy, bus_if.full, $time);
         end
      end
   end

   initial begin
      tbl[0] = '{1'b1, 8'h00, 16'h0000, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 8'h01, 16'h0001, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 8'h3F, 16'h003F, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 8'h40, 16'hFFFF, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 8'hFF, 16'hFFFF, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 8'h00, 16'hFFFF, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 8'h2A, 16'h002A, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 8'hFF, 16'h002A, 1'b0, 1'b0};

      bus_if.load    = 1'b0;
      bus_if.din     = '0;
      bus_if.din_vld = 1'b0;
      bus_if.rd      = 1'b0;
      bus_if.addr    = '0;

      // ---- reset state
      #12;
      chk("rst.busy", 32'(bus_if.busy), 32'd0);
      chk("rst.full", 32'(bus_if.full), 32'd0);
      chk_rd("rst", 16'h0000, 1'b0, 1'b0);

      // ---- first load honoured on first edge after release; 64 words din=i
      rst_n       = 1'b1;
      bus_if.load = 1'b1;
      step();
      bus_if.load = 1'b0;
      chk("load0.busy", 32'(bus_if.busy), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         bus_if.din_vld = 1'b1;
         bus_if.din     = 16'(i);
         step();
         chk($sformatf("fill%0d.busy", i), 32'(bus_if.busy), 32'(i < DEPTH - 1));
         chk($sformatf("fill%0d.full", i), 32'(bus_if.full), 32'(i == DEPTH - 1));
      end
      bus_if.din_vld = 1'b0;

      // ---- table-driven reads in SERVE
      for (int t = 0; t < 8; t++) begin
         bus_if.rd   = tbl[t].rd;
         bus_if.addr = tbl[t].addr;
         step();
         chk_rd($sformatf("tbl%0d", t), tbl[t].exp_data, tbl[t].exp_vld, tbl[t].exp_err);
      end

      // ---- back-to-back sweep of every address
      for (int i = 0; i < DEPTH; i++) begin
         bus_if.rd   = 1'b1;
         bus_if.addr = 8'(i);
         step();
         chk_rd($sformatf("sweep%0d", i), 16'(i), 1'b1, 1'b0);
      end

      // ---- load and rd in the same SERVE cycle: old contents returned
      bus_if.load = 1'b1;
      bus_if.rd   = 1'b1;
      bus_if.addr = 8'd5;
      step();
      bus_if.load = 1'b0;
      bus_if.rd   = 1'b0;
      chk_rd("ldrd", 16'h0005, 1'b1, 1'b0);
      chk("ldrd.full", 32'(bus_if.full), 32'd0);
      chk("ldrd.busy", 32'(bus_if.busy), 32'd1);

      // ---- gapped load (din_vld every other cycle) with a read during LOAD
      for (int k = 0; k < 2 * DEPTH - 1; k++) begin
         bus_if.din_vld = (k % 2 == 0);
         bus_if.din     = 16'h0100 + 16'(k / 2);
         bus_if.rd      = (k == 10);
         bus_if.addr    = 8'd3;
         step();
         if (k == 10) chk_rd("rd_in_load", 16'hFFFF, 1'b0, 1'b1);
         chk($sformatf("gap%0d.full", k), 32'(bus_if.full), 32'(k == 2 * DEPTH - 2));
      end
      bus_if.din_vld = 1'b0;
      bus_if.rd      = 1'b1;
      bus_if.addr    = 8'd9;
      step();
      chk_rd("gap.rd9", 16'h0109, 1'b1, 1'b0);
      bus_if.addr = 8'd63;
      step();
      chk_rd("gap.rd63", 16'h013F, 1'b1, 1'b0);
      bus_if.rd = 1'b0;

      // ---- reset mid-load clears outputs immediately
      bus_if.load = 1'b1;
      step();
      bus_if.load = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus_if.din_vld = 1'b1;
         bus_if.din     = 16'h5555;
         step();
      end
      bus_if.din_vld = 1'b0;
      chk("pre_rst.busy", 32'(bus_if.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst.busy", 32'(bus_if.busy), 32'd0);
      chk("async_rst.full", 32'(bus_if.full), 32'd0);
      chk_rd("async_rst", 16'h0000, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;

      // ---- IDLE ignores din_vld; reads rejected
      for (int i = 0; i < 3; i++) begin
         bus_if.din_vld = 1'b1;
         bus_if.din     = 16'h7777;
         step();
         chk($sformatf("idle%0d.busy", i), 32'(bus_if.busy), 32'd0);
      end
      bus_if.din_vld = 1'b0;
      bus_if.rd      = 1'b1;
      bus_if.addr    = 8'd0;
      step();
      chk_rd("idle.rd", 16'hFFFF, 1'b0, 1'b1);
      bus_if.rd = 1'b0;
      step();
      chk_rd("idle.hold", 16'hFFFF, 1'b0, 1'b0);
      chk("idle.full", 32'(bus_if.full), 32'd0);

      // ---- reload with constant 16'h1122
      bus_if.load = 1'b1;
      step();
      bus_if.load = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         bus_if.din_vld = 1'b1;
         bus_if.din     = 16'h1122;
         step();
      end
      bus_if.din_vld = 1'b0;
      chk("reload.full", 32'(bus_if.full), 32'd1);
      bus_if.rd = 1'b1;
      bus_if.addr = 8'd0;   step(); chk_rd("reload.rd0",  16'h1122, 1'b1, 1'b0);
      bus_if.addr = 8'd29;  step(); chk_rd("reload.rd29", 16'h1122, 1'b1, 1'b0);
      bus_if.addr = 8'd63;  step(); chk_rd("reload.rd63", 16'h1122, 1'b1, 1'b0);
      bus_if.addr = 8'h80;  step(); chk_rd("reload.rd80", 16'hFFFF, 1'b1, 1'b1);
      bus_if.rd = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
